// File: rtl/pipe_pkg.sv
// Shared definitions for the decode-stage hazard controller: instruction
// field positions, FSM states, scoreboard entry layout and the 5-to-32 decoder.
package pipe_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;

   localparam int OP_MSB = 31;
   localparam int OP_LSB = 26;
   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;
   localparam int RD_MSB = 15;
   localparam int RD_LSB = 11;

   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] dest;
   } sb_entry_t;

   function automatic logic [31:0] dec5to32(input logic [4:0] sel);
      dec5to32 = 32'd1 << sel;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (reset)
         count_reg <= '0;
      else if (en && (count_reg != '1))
         count_reg <= count_reg + CNT_W'(1);
   end

   assign count = count_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage issue/stall controller: tracks in-flight destinations and
// freezes IF/ID while the decode instruction reads one of them.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      ibus_id,
   input  logic             id_valid,
   input  logic             flush,
   output logic             hold_if,
   output logic             bubble_ex,
   output logic [31:0]      dsel_id,
   output logic [31:0]      sb_busy,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] instr_count
);

   state_t     state_reg;
   sb_entry_t  sb_reg [DEPTH];

   logic [5:0] opcode;
   logic [4:0] rs;
   logic [4:0] rt;
   logic [4:0] rd;
   logic       rtype;
   logic [4:0] dest;
   logic       dest_valid;
   logic       hazard;
   logic       in_flush;
   logic       issue;
   logic       unused_imm;

   logic [DEPTH-1:0] match;
   logic [31:0]      busy_vec [DEPTH];

   assign opcode     = ibus_id[OP_MSB:OP_LSB];
   assign rs         = ibus_id[RS_MSB:RS_LSB];
   assign rt         = ibus_id[RT_MSB:RT_LSB];
   assign rd         = ibus_id[RD_MSB:RD_LSB];
   assign unused_imm = ^ibus_id[RD_LSB-1:0];
   assign rtype      = (opcode == OP_RTYPE);
   assign dest       = rtype ? rd : rt;
   assign dest_valid = (dest != 5'd0);

   // Register 0 is never written, so it can never be a hazard source.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign match[gi] = sb_reg[gi].valid &&
                         (((sb_reg[gi].dest == rs) && (rs != 5'd0)) ||
                          (rtype && (sb_reg[gi].dest == rt) && (rt != 5'd0)));
      assign busy_vec[gi] = sb_reg[gi].valid ? (dec5to32(sb_reg[gi].dest) & ~32'd1)
                                             : 32'd0;
   end

   always_comb begin
      sb_busy = 32'd0;
      for (int k = 0; k < DEPTH; k++)
         sb_busy = sb_busy | busy_vec[k];
   end

   assign hazard    = id_valid && (|match);
   assign in_flush  = flush || (state_reg == FLUSH);
   assign hold_if   = hazard && !in_flush;
   assign bubble_ex = in_flush || hazard || !id_valid;
   assign issue     = !bubble_ex;
   assign dsel_id   = (issue && dest_valid) ? dec5to32(dest) : 32'd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= RUN;
      end else if (flush) begin
         state_reg <= FLUSH;
      end else begin
         case (state_reg)
            RUN:     state_reg <= hazard ? STALL : RUN;
            STALL:   state_reg <= hazard ? STALL : RUN;
            FLUSH:   state_reg <= RUN;
            default: state_reg <= RUN;
         endcase
      end
   end

   // Entry 0 is the instruction entering EX; a bubble enters as invalid.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int k = 0; k < DEPTH; k++)
            sb_reg[k] <= '0;
      end else begin
         sb_reg[0] <= issue ? sb_entry_t'{valid: dest_valid, dest: dest} : '0;
         for (int k = 1; k < DEPTH; k++)
            sb_reg[k] <= sb_reg[k-1];
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (hold_if),
      .count (stall_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (issue),
      .count (instr_count)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a queue-based scoreboard; a second
// instance with 2-bit counters exercises counter saturation.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ibus_id;
   logic        id_valid;
   logic        flush;

   logic        hold_if, bubble_ex;
   logic [31:0] dsel_id, sb_busy;
   logic [15:0] stall_count, instr_count;

   logic        s_hold_if, s_bubble_ex;
   logic [31:0] s_dsel_id, s_sb_busy;
   logic [1:0]  s_stall_count, s_instr_count;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.DEPTH(2), .CNT_W(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .ibus_id     (ibus_id),
      .id_valid    (id_valid),
      .flush       (flush),
      .hold_if     (hold_if),
      .bubble_ex   (bubble_ex),
      .dsel_id     (dsel_id),
      .sb_busy     (sb_busy),
      .stall_count (stall_count),
      .instr_count (instr_count)
   );

   pipe_hazard_ctrl #(.DEPTH(2), .CNT_W(2)) dut_sat (
      .clk         (clk),
      .reset       (reset),
      .ibus_id     (ibus_id),
      .id_valid    (id_valid),
      .flush       (flush),
      .hold_if     (s_hold_if),
      .bubble_ex   (s_bubble_ex),
      .dsel_id     (s_dsel_id),
      .sb_busy     (s_sb_busy),
      .stall_count (s_stall_count),
      .instr_count (s_instr_count)
   );

   typedef struct packed {
      logic        hold;
      logic        bub;
      logic [31:0] dsel;
      logic [31:0] busy;
      logic [15:0] stall;
      logic [15:0] instr;
   } exp_t;

   exp_t  exp_q [$];
   string name_q [$];
   int    compared   = 0;
   int    mismatched = 0;

   function automatic logic [31:0] rt_ins(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d);
      rt_ins = {6'b000000, s, t, d, 11'd0};
   endfunction

   function automatic logic [31:0] im_ins(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t);
      im_ins = {op, s, t, 16'd5};
   endfunction

   task automatic chk(input string nm, input string fld, input logic [31:0] act,
                      input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
      end
   endtask

   task automatic step(input logic r, input logic f, input logic v, input logic [31:0] ib,
                       input logic eh, input logic eb, input logic [31:0] ed,
                       input logic [31:0] ebusy, input int es, input int ei,
                       input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      reset    = r;
      flush    = f;
      id_valid = v;
      ibus_id  = ib;
      e.hold  = eh;
      e.bub   = eb;
      e.dsel  = ed;
      e.busy  = ebusy;
      e.stall = 16'(es);
      e.instr = 16'(ei);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: outputs are combinational, so each cycle is one transaction.
   initial begin
      exp_t        e;
      string       nm;
      logic [31:0] sat_s, sat_i;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            sat_s = (e.stall > 16'd3) ? 32'd3 : {16'd0, e.stall};
            sat_i = (e.instr > 16'd3) ? 32'd3 : {16'd0, e.instr};
            chk(nm, "hold_if",   {31'd0, hold_if},   {31'd0, e.hold});
            chk(nm, "bubble_ex", {31'd0, bubble_ex}, {31'd0, e.bub});
            chk(nm, "dsel_id",   dsel_id,            e.dsel);
            chk(nm, "sb_busy",   sb_busy,            e.busy);
            chk(nm, "stall_cnt", {16'd0, stall_count}, {16'd0, e.stall});
            chk(nm, "instr_cnt", {16'd0, instr_count}, {16'd0, e.instr});
            chk(nm, "sat_stall", {30'd0, s_stall_count}, sat_s);
            chk(nm, "sat_instr", {30'd0, s_instr_count}, sat_i);
            $display("txn %-12s hold=%0b bub=%0b dsel=%h busy=%h stall=%0d instr=%0d",
                     nm, hold_if, bubble_ex, dsel_id, sb_busy, stall_count, instr_count);
         end
      end
   end

   initial begin
      reset    = 1'b1;
      flush    = 1'b0;
      id_valid = 1'b0;
      ibus_id  = 32'd0;
      repeat (2) @(posedge clk);

      //   rst flush vld instr                 hold bub dsel        busy        S  I
      step(0, 0, 0, 32'd0,                   0, 1, 32'h0,      32'h0,      0, 0,  "reset_idle");
      // independent pair
      step(0, 0, 1, rt_ins(1, 2, 3),         0, 0, 32'h8,      32'h0,      0, 0,  "add_r3");
      step(0, 0, 1, im_ins(6'h08, 4, 5),     0, 0, 32'h20,     32'h8,      0, 1,  "addi_r5");
      step(0, 0, 0, 32'd0,                   0, 1, 32'h0,      32'h28,     0, 2,  "idle_a");
      step(0, 0, 0, 32'd0,                   0, 1, 32'h0,      32'h20,     0, 2,  "idle_b");
      step(0, 0, 0, 32'd0,                   0, 1, 32'h0,      32'h0,      0, 2,  "idle_c");
      // RAW on rs, 2-cycle stall
      step(0, 0, 1, rt_ins(1, 2, 7),         0, 0, 32'h80,     32'h0,      0, 2,  "add_r7");
      step(0, 0, 1, rt_ins(7, 3, 8),         1, 1, 32'h0,      32'h80,     0, 3,  "sub_stall1");
      step(0, 0, 1, rt_ins(7, 3, 8),         1, 1, 32'h0,      32'h80,     1, 3,  "sub_stall2");
      step(0, 0, 1, rt_ins(7, 3, 8),         0, 0, 32'h100,    32'h0,      2, 3,  "sub_issue");
      step(0, 0, 0, 32'd0,                   0, 1, 32'h0,      32'h100,    2, 4,  "idle_d");
      step(0, 0, 0, 32'd0,                   0, 1, 32'h0,      32'h100,    2, 4,  "idle_e");
      // immediate: rs is a source, rt is not
      step(0, 0, 1, im_ins(6'h08, 0, 6),     0, 0, 32'h40,     32'h0,      2, 4,  "addi_r6");
      step(0, 0, 1, im_ins(6'h0d, 6, 9),     1, 1, 32'h0,      32'h40,     2, 5,  "ori_stall1");
      step(0, 0, 1, im_ins(6'h0d, 6, 9),     1, 1, 32'h0,      32'h40,     3, 5,  "ori_stall2");
      step(0, 0, 1, im_ins(6'h0d, 6, 9),     0, 0, 32'h200,    32'h0,      4, 5,  "ori_issue");
      step(0, 0, 1, im_ins(6'h0d, 1, 9),     0, 0, 32'h200,    32'h200,    4, 6,  "imm_rt_pend");
      step(0, 0, 0, 32'd0,                   0, 1, 32'h0,      32'h200,    4, 7,  "idle_f");
      step(0, 0, 0, 32'd0,                   0, 1, 32'h0,      32'h200,    4, 7,  "idle_g");
      // r0 destination
      step(0, 0, 1, rt_ins(1, 2, 0),         0, 0, 32'h0,      32'h0,      4, 7,  "add_r0");
      step(0, 0, 1, rt_ins(0, 0, 10),        0, 0, 32'h400,    32'h0,      4, 8,  "read_r0");
      step(0, 0, 0, 32'd0,                   0, 1, 32'h0,      32'h400,    4, 9,  "idle_h");
      step(0, 0, 0, 32'd0,                   0, 1, 32'h0,      32'h400,    4, 9,  "idle_i");
      // flush during stall
      step(0, 0, 1, rt_ins(1, 2, 11),        0, 0, 32'h800,    32'h0,      4, 9,  "add_r11");
      step(0, 0, 1, rt_ins(11, 0, 12),       1, 1, 32'h0,      32'h800,    4, 10, "dep_stall");
      step(0, 1, 1, rt_ins(11, 0, 12),       0, 1, 32'h0,      32'h800,    5, 10, "flush_cyc");
      step(0, 0, 1, rt_ins(11, 0, 12),       0, 1, 32'h0,      32'h0,      5, 10, "flush_state");
      step(0, 0, 1, rt_ins(11, 0, 12),       0, 0, 32'h1000,   32'h0,      5, 10, "post_flush");
      step(0, 0, 0, 32'd0,                   0, 1, 32'h0,      32'h1000,   5, 11, "idle_j");
      // reset mid-stall
      step(0, 0, 1, rt_ins(1, 2, 13),        0, 0, 32'h2000,   32'h1000,   5, 11, "add_r13");
      step(0, 0, 1, rt_ins(13, 0, 14),       1, 1, 32'h0,      32'h2000,   5, 12, "pre_rst_stl");
      step(1, 0, 1, rt_ins(13, 0, 14),       1, 1, 32'h0,      32'h2000,   6, 12, "rst_in_stall");
      step(0, 0, 1, rt_ins(13, 0, 14),       0, 0, 32'h4000,   32'h0,      0, 0,  "post_reset");
      // stalls after reset; 2-bit instance saturates again
      step(0, 0, 1, rt_ins(14, 0, 15),       1, 1, 32'h0,      32'h4000,   0, 1,  "chain1_s1");
      step(0, 0, 1, rt_ins(14, 0, 15),       1, 1, 32'h0,      32'h4000,   1, 1,  "chain1_s2");
      step(0, 0, 1, rt_ins(14, 0, 15),       0, 0, 32'h8000,   32'h0,      2, 1,  "chain1_iss");
      step(0, 0, 1, rt_ins(15, 15, 16),      1, 1, 32'h0,      32'h8000,   2, 2,  "chain2_s1");
      step(0, 0, 1, rt_ins(15, 15, 16),      1, 1, 32'h0,      32'h8000,   3, 2,  "chain2_s2");
      step(0, 0, 1, rt_ins(15, 15, 16),      0, 0, 32'h10000,  32'h0,      4, 2,  "chain2_iss");
      step(0, 0, 0, 32'd0,                   0, 1, 32'h0,      32'h10000,  4, 3,  "idle_end");

      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         if (exp_q.size() == 0) break;
      end
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
